hazard_unit_mc: RTL

HAZARD_UNIT_MC -- requirements
Module: hazard_unit_mc

---
 rtl/hazard_unit_mc.sv | 116 +++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: pipeline hazard unit with operand forwarding, load-use and
// multi-cycle (mul/div) scoreboard stalls, and branch flushes.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_Rs1B, i_Rs2B, i_MdOpB   decode-stage sources, mul/div flag
//   i_Rs1C, i_Rs2C, i_RdC     execute-stage sources/destination
//   i_ResultSrcC, i_RegWriteC execute-stage result select (01 = load), write enable
//   i_MdStartC                execute stage issues a mul/div op
//   i_RdD, i_RegWriteD        memory-stage destination/write enable
//   i_RdE, i_RegWriteE        writeback-stage destination/write enable
//   i_PCSrcA                  taken branch/jump
//   o_ForwardAH, o_ForwardBH  operand select: 00 regfile, 10 D result, 01 E result
//   o_StallA, o_StallB        hold PC and B register
//   o_FlushB, o_FlushC        bubble B and C registers
//   o_MdBusy, o_MdDone        mul/div occupied, one-cycle completion pulse
//   o_MdRdOut                 destination of the mul/div op in flight
module hazard_unit_mc #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MD_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_Rs1B,
    input  logic [REG_ADDR_W-1:0] i_Rs2B,
    input  logic                  i_MdOpB,
    input  logic [REG_ADDR_W-1:0] i_Rs1C,
    input  logic [REG_ADDR_W-1:0] i_Rs2C,
    input  logic [REG_ADDR_W-1:0] i_RdC,
    input  logic [1:0]            i_ResultSrcC,
    input  logic                  i_RegWriteC,
    input  logic                  i_MdStartC,
    input  logic [REG_ADDR_W-1:0] i_RdD,
    input  logic                  i_RegWriteD,
    input  logic [REG_ADDR_W-1:0] i_RdE,
    input  logic                  i_RegWriteE,
    input  logic                  i_PCSrcA,
    output logic [1:0]            o_ForwardAH,
    output logic [1:0]            o_ForwardBH,
    output logic                  o_StallA,
    output logic                  o_StallB,
    output logic                  o_FlushB,
    output logic                  o_FlushC,
    output logic                  o_MdBusy,
    output logic                  o_MdDone,
    output logic [REG_ADDR_W-1:0] o_MdRdOut
);
    localparam int NUM_REGS = 2**REG_ADDR_W;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t                r_state, w_state_nx;
    logic [3:0]            r_cnt, w_cnt_nx;
    logic [NUM_REGS-1:0]   r_pending, w_pending_nx;
    logic [REG_ADDR_W-1:0] r_md_rd, w_md_rd_nx;
    logic [1:0]            w_fwd_a, w_fwd_b;
    logic                  w_lw_haz, w_md_haz, w_haz, w_md_busy, w_md_done;

    // D beats E so the youngest producer wins
    assign w_fwd_a = (i_RegWriteD && i_RdD != '0 && i_RdD == i_Rs1C) ? 2'b10 :
                     (i_RegWriteE && i_RdE != '0 && i_RdE == i_Rs1C) ? 2'b01 : 2'b00;
    assign w_fwd_b = (i_RegWriteD && i_RdD != '0 && i_RdD == i_Rs2C) ? 2'b10 :
                     (i_RegWriteE && i_RdE != '0 && i_RdE == i_Rs2C) ? 2'b01 : 2'b00;

    // DATA_WIDTH carries no data here; the term is constant-true
    assign w_lw_haz  = (i_ResultSrcC == 2'b01) && i_RegWriteC && i_RdC != '0 &&
                       (i_RdC == i_Rs1B || i_RdC == i_Rs2B) && (DATA_WIDTH > 0);
    assign w_md_busy = (r_state == S_BUSY);
    assign w_md_done = w_md_busy && r_cnt == 4'd0;
    // a second mul/div may follow in the done cycle since the unit frees at that edge
    assign w_md_haz  = r_pending[i_Rs1B] | r_pending[i_Rs2B] | (i_MdOpB & w_md_busy & ~w_md_done);
    // a taken branch squashes B anyway, so stalling it would be pointless
    assign w_haz     = (w_lw_haz | w_md_haz) & ~i_PCSrcA;

    assign o_ForwardAH = rst ? 2'b00 : w_fwd_a;
    assign o_ForwardBH = rst ? 2'b00 : w_fwd_b;
    assign o_StallA    = ~rst & w_haz;
    assign o_StallB    = ~rst & w_haz;
    assign o_FlushB    = ~rst & i_PCSrcA;
    assign o_FlushC    = ~rst & (i_PCSrcA | w_haz);
    assign o_MdBusy    = w_md_busy;
    assign o_MdDone    = w_md_done;
    assign o_MdRdOut   = r_md_rd;

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_pending_nx = r_pending;
        w_md_rd_nx   = r_md_rd;
        if (r_state == S_IDLE && i_MdStartC) begin
            w_state_nx           = S_BUSY;
            w_cnt_nx             = 4'(MD_LATENCY - 1);
            w_md_rd_nx           = i_RdC;
            w_pending_nx[i_RdC]  = (i_RdC != '0);
        end else if (w_md_done) begin
            w_state_nx             = S_IDLE;
            w_pending_nx[r_md_rd]  = 1'b0;
        end else if (w_md_busy) begin
            w_cnt_nx = r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_pending <= '0;
            r_md_rd   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_pending <= w_pending_nx;
            r_md_rd   <= w_md_rd_nx;
        end
    end
endmodule
